// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - requester, multiplier and response signals of the shared-multiplier scheduler
interface mult_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [DATA_WIDTH-1:0]         m_a;
  logic [DATA_WIDTH-1:0]         m_b;
  logic [2*DATA_WIDTH-1:0]       m_c;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [2*DATA_WIDTH-1:0]       rsp_z;

  modport slave (
    input  req_valid, req_a, req_b, m_c, rsp_ready,
    output req_ready, m_a, m_b, rsp_valid, rsp_id, rsp_z
  );

  modport master (
    output req_valid, req_a, req_b, m_c, rsp_ready,
    input  req_ready, m_a, m_b, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler sharing one pipelined multiplier among requesters
// Credit covers FIFO entries plus in-flight products, so every exiting product has a slot.
module mult_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = MULT_LAT + 2
) (
  input logic         clk_i,
  input logic         rst_i,
  mult_sched_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [ID_W-1:0]       last_q, last_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [DATA_WIDTH-1:0] ma_q, mb_q;
  logic [MULT_LAT-1:0]   pv_q;
  logic [ID_W-1:0]       pid_q [MULT_LAT];
  logic [PW-1:0]         fz_q  [FIFO_DEPTH];
  logic [ID_W-1:0]       fid_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  grant_vld;
  logic [ID_W-1:0]       grant_idx;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!rst_i && credit_q != '0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_q) + k) % NUM_REQ;
        if (!grant_vld && bus.req_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
  end

  assign sel_a = bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b = bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.m_a       = rst_i ? '0 : (grant_vld ? sel_a : ma_q);
  assign bus.m_b       = rst_i ? '0 : (grant_vld ? sel_b : mb_q);

  assign bus.rsp_valid = !rst_i && (cnt_q != '0);
  assign bus.rsp_id    = bus.rsp_valid ? fid_q[rd_q] : '0;
  assign bus.rsp_z     = bus.rsp_valid ? fz_q[rd_q] : '0;

  assign push = pv_q[MULT_LAT-1];
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  // A pop returns its credit only from the next cycle, via the registered count.
  assign last_d   = grant_vld ? grant_idx : last_q;
  assign credit_d = credit_q - CW'(grant_vld) + CW'(pop);
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  assign wr_d     = !push ? wr_q : ((wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1));
  assign rd_d     = !pop  ? rd_q : ((rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q   <= ID_W'(NUM_REQ - 1);
      credit_q <= CW'(FIFO_DEPTH);
      ma_q     <= '0;
      mb_q     <= '0;
      pv_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      last_q   <= last_d;
      credit_q <= credit_d;
      if (grant_vld) begin
        ma_q <= sel_a;
        mb_q <= sel_b;
      end
      for (int i = MULT_LAT - 1; i >= 1; i--) begin
        pv_q[i] <= pv_q[i-1];
      end
      pv_q[0] <= grant_vld;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity lives in pv_q and cnt_q.
  always_ff @(posedge clk_i) begin
    for (int i = MULT_LAT - 1; i >= 1; i--) begin
      pid_q[i] <= pid_q[i-1];
    end
    pid_q[0] <= grant_idx;
    if (push) begin
      fz_q[wr_q]  <= bus.m_c;
      fid_q[wr_q] <= pid_q[MULT_LAT-1];
    end
  end
endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - randomized and directed bench for mult_sched against a queue-based reference
module tb_mult_sched;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int ML = 2;
  localparam int FD = ML + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  mult_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_LAT(ML), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Shared multiplier with ML cycles of latency
  logic [2*DW-1:0] hist [ML];
  always @(posedge clk) begin
    hist[0] <= 64'(bus.m_a) * 64'(bus.m_b);
    for (int i = 1; i < ML; i++) hist[i] <= hist[i-1];
  end
  assign bus.m_c = hist[ML-1];

  typedef struct {
    int          id;
    logic [63:0] z;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  int          last_g;
  logic [DW-1:0] held_a, held_b;
  int          cyc, total, bad, obs_issue;

  logic [NR-1:0] v_valid;
  logic [DW-1:0] v_a [NR];
  logic [DW-1:0] v_b [NR];
  logic          v_rready, v_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    int          g;
    logic [NR-1:0] er;
    logic        ev;
    rsp_t        e;
    @(negedge clk);
    rst           = v_rst;
    bus.rsp_ready = v_rready;
    bus.req_valid = v_valid;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*DW +: DW] = v_a[i];
      bus.req_b[i*DW +: DW] = v_b[i];
    end
    #1;
    if (v_rst) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_rsp_z", bus.rsp_z, 64'd0);
      chk("rst_m_a", 64'(bus.m_a), 64'd0);
      chk("rst_m_b", 64'(bus.m_b), 64'd0);
      q.delete();
      last_g = NR - 1;
      held_a = '0;
      held_b = '0;
    end else begin
      g = -1;
      if (q.size() < FD) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (last_g + k) % NR;
          if (g < 0 && v_valid[idx]) g = idx;
        end
      end
      er = (g >= 0) ? (NR'(1) << g) : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      obs_issue += int'(|(bus.req_ready & v_valid));
      if (g >= 0) begin
        held_a = v_a[g];
        held_b = v_b[g];
        last_g = g;
        e.id   = g;
        e.z    = 64'(v_a[g]) * 64'(v_b[g]);
        e.due  = cyc + ML + 1;
        q.push_back(e);
      end
      chk("m_a", 64'(bus.m_a), 64'(held_a));
      chk("m_b", 64'(bus.m_b), 64'(held_b));
      ev = (q.size() > 0) && (q[0].due <= cyc);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      if (ev) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
        chk("rsp_z", bus.rsp_z, q[0].z);
        if (v_rready) void'(q.pop_front());
      end
    end
    cyc++;
  endtask

  initial begin
    int n0;
    total = 0; bad = 0; cyc = 0; obs_issue = 0;
    last_g = NR - 1; held_a = '0; held_b = '0;
    v_rst = 1'b1; v_rready = 1'b1; v_valid = '0;
    for (int i = 0; i < NR; i++) begin v_a[i] = '0; v_b[i] = '0; end
    repeat (2) tick();
    v_rst = 1'b0;

    // single request, first cycle after reset
    v_valid = 4'b0001; v_a[0] = 32'd342; v_b[0] = 32'd25;
    tick();
    v_valid = '0;
    repeat (5) tick();

    // full contention
    for (int i = 0; i < NR; i++) begin v_a[i] = DW'(i + 1); v_b[i] = 32'd10; end
    v_valid = 4'b1111;
    repeat (12) tick();
    v_valid = '0;
    repeat (6) tick();

    // backpressure: exactly FD issues, then drain
    v_rready = 1'b0; v_valid = 4'b0100; v_a[2] = 32'd77; v_b[2] = 32'd9;
    n0 = obs_issue;
    repeat (10) tick();
    chk("bp_issue_count", 64'(obs_issue - n0), 64'(FD));
    v_rready = 1'b1;
    repeat (12) tick();
    v_valid = '0;
    repeat (6) tick();

    // zero operands from requester 1
    v_valid = 4'b0010;
    v_a[1] = 32'd0; v_b[1] = 32'd0; tick();
    v_a[1] = 32'd0; v_b[1] = 32'd1; tick();
    v_a[1] = 32'd1; v_b[1] = 32'd0; tick();
    v_valid = '0;
    repeat (6) tick();

    // reset while products are in flight
    for (int i = 0; i < NR; i++) begin v_a[i] = $urandom; v_b[i] = $urandom; end
    v_valid = 4'b0111;
    repeat (3) tick();
    v_valid = '0; v_rst = 1'b1;
    tick();
    v_rst = 1'b0;
    repeat (6) tick();
    v_valid = 4'b0001; v_a[0] = 32'd1234; v_b[0] = 32'd5678;
    tick();
    v_valid = '0;
    repeat (5) tick();

    // fairness and pointer hold over idle cycles
    v_valid = 4'b1000; tick();
    v_valid = '0; repeat (3) tick();
    v_valid = 4'b1001; repeat (2) tick();
    v_valid = '0; repeat (5) tick();

    // randomized traffic with occasional reset
    repeat (400) begin
      v_valid  = NR'($urandom);
      for (int i = 0; i < NR; i++) begin v_a[i] = $urandom; v_b[i] = $urandom; end
      v_rready = ($urandom_range(0, 9) < 7);
      v_rst    = ($urandom_range(0, 149) == 0);
      tick();
    end
    v_rst = 1'b0; v_valid = '0; v_rready = 1'b1;
    repeat (12) tick();
    chk("drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
